// File: rtl/ps2_mouse_pkg.sv
// Shared constants, types and helpers for the PS/2 mouse packet decoder.
package ps2_mouse_pkg;

  localparam int HDR_L    = 0;
  localparam int HDR_R    = 1;
  localparam int HDR_M    = 2;
  localparam int HDR_SYNC = 3;
  localparam int HDR_XS   = 4;
  localparam int HDR_YS   = 5;
  localparam int HDR_XO   = 6;
  localparam int HDR_YO   = 7;

  localparam logic [7:0] PS2_ACK = 8'hFA;
  localparam logic [7:0] PS2_BAT = 8'hAA;

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_e;

  // Header minus the always-one sync bit, held until the packet completes.
  typedef struct packed {
    logic yo, xo, ys, xs, m, r, l;
  } hdr_t;

  typedef struct packed {
    logic       yo, xo, m, r, l;
    logic [8:0] dx;
    logic [8:0] dy;
  } pkt_t;

  function automatic int timeout_cycles(input int clk_hz, input int us);
    return (clk_hz / 1000000) * us;
  endfunction

endpackage

// File: rtl/ps2_cursor_accum.sv
// Absolute cursor position: signed accumulate of packet motion, clamp to screen, recentre.
module ps2_cursor_accum
  import ps2_mouse_pkg::*;
#(
  parameter int X_MAX = 639,
  parameter int Y_MAX = 479,
  parameter int POS_W = 10
) (
  input  logic             iCLK_50,
  input  logic             iRST,
  input  logic [8:0]       iDX,
  input  logic [8:0]       iDY,
  input  logic             iUPD,
  input  logic             iCLR,
  output logic [POS_W-1:0] oCUR_X,
  output logic [POS_W-1:0] oCUR_Y
);

  localparam logic [POS_W-1:0]        X_CTR = POS_W'(X_MAX / 2);
  localparam logic [POS_W-1:0]        Y_CTR = POS_W'(Y_MAX / 2);
  localparam logic [POS_W-1:0]        X_LIM = POS_W'(X_MAX);
  localparam logic [POS_W-1:0]        Y_LIM = POS_W'(Y_MAX);
  localparam logic signed [POS_W+1:0] X_LIM_S = (POS_W+2)'(X_MAX);
  localparam logic signed [POS_W+1:0] Y_LIM_S = (POS_W+2)'(Y_MAX);

  logic [POS_W-1:0]        x_q, x_d, y_q, y_d, x_clamp, y_clamp;
  logic signed [POS_W+1:0] sum_x, sum_y;

  always_comb begin
    // Screen Y grows downward while mouse Y grows upward, hence the subtract.
    sum_x = $signed({2'b00, x_q}) + $signed({{(POS_W-7){iDX[8]}}, iDX});
    sum_y = $signed({2'b00, y_q}) - $signed({{(POS_W-7){iDY[8]}}, iDY});

    if (sum_x[POS_W+1])       x_clamp = '0;
    else if (sum_x > X_LIM_S) x_clamp = X_LIM;
    else                      x_clamp = sum_x[POS_W-1:0];

    if (sum_y[POS_W+1])       y_clamp = '0;
    else if (sum_y > Y_LIM_S) y_clamp = Y_LIM;
    else                      y_clamp = sum_y[POS_W-1:0];

    x_d = x_q;
    y_d = y_q;
    if (iCLR) begin
      x_d = X_CTR;
      y_d = Y_CTR;
    end else if (iUPD) begin
      x_d = x_clamp;
      y_d = y_clamp;
    end
  end

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      x_q <= X_CTR;
      y_q <= Y_CTR;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign oCUR_X = x_q;
  assign oCUR_Y = y_q;

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// Assembles 3-byte PS/2 stream packets with header sync and inter-byte timeout,
// registers button/motion outputs and drives the cursor accumulator.
module ps2_mouse_packet_decoder
  import ps2_mouse_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int TIMEOUT_US = 2000,
  parameter int X_MAX      = 639,
  parameter int Y_MAX      = 479,
  parameter int POS_W      = 10
) (
  input  logic             iCLK_50,
  input  logic             iRST,
  input  logic [7:0]       iBYTE,
  input  logic             iBYTE_VALID,
  input  logic             iCLR_POS,
  output logic             oLEFBUT,
  output logic             oRIGBUT,
  output logic             oMIDBUT,
  output logic [8:0]       oDX,
  output logic [8:0]       oDY,
  output logic             oX_OVF,
  output logic             oY_OVF,
  output logic             oPKT_VALID,
  output logic             oSYNC_ERR,
  output logic [POS_W-1:0] oCUR_X,
  output logic [POS_W-1:0] oCUR_Y
);

  localparam int TIMEOUT_CYC = timeout_cycles(CLK_HZ, TIMEOUT_US);
  localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hdr_t             hdr_q, hdr_d;
  logic [7:0]       b1_q, b1_d;
  pkt_t             pkt_q, pkt_d;
  logic             pkt_vld_q, pkt_vld_d;
  logic             sync_err_q, sync_err_d;
  logic [8:0]       dx_eff, dy_eff;

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    hdr_d      = hdr_q;
    b1_d       = b1_q;
    pkt_d      = pkt_q;
    pkt_vld_d  = 1'b0;
    sync_err_d = 1'b0;

    unique case (state_q)
      WAIT_B0: begin
        if (iBYTE_VALID && iBYTE != PS2_ACK && iBYTE != PS2_BAT) begin
          if (!iBYTE[HDR_SYNC]) begin
            sync_err_d = 1'b1;
          end else begin
            hdr_d.l  = iBYTE[HDR_L];
            hdr_d.r  = iBYTE[HDR_R];
            hdr_d.m  = iBYTE[HDR_M];
            hdr_d.xs = iBYTE[HDR_XS];
            hdr_d.ys = iBYTE[HDR_YS];
            hdr_d.xo = iBYTE[HDR_XO];
            hdr_d.yo = iBYTE[HDR_YO];
            state_d  = WAIT_B1;
          end
        end
      end
      WAIT_B1, WAIT_B2: begin
        // A byte in the final timeout cycle still counts as on time.
        if (iBYTE_VALID) begin
          if (state_q == WAIT_B1) begin
            b1_d    = iBYTE;
            state_d = WAIT_B2;
          end else begin
            pkt_d.l   = hdr_q.l;
            pkt_d.r   = hdr_q.r;
            pkt_d.m   = hdr_q.m;
            pkt_d.xo  = hdr_q.xo;
            pkt_d.yo  = hdr_q.yo;
            pkt_d.dx  = {hdr_q.xs, b1_q};
            pkt_d.dy  = {hdr_q.ys, iBYTE};
            pkt_vld_d = 1'b1;
            state_d   = WAIT_B0;
          end
        end else if (cnt_q == CNT_LAST) begin
          sync_err_d = 1'b1;
          state_d    = WAIT_B0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = WAIT_B0;
    endcase

    dx_eff = pkt_d.xo ? 9'd0 : pkt_d.dx;
    dy_eff = pkt_d.yo ? 9'd0 : pkt_d.dy;
  end

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      state_q    <= WAIT_B0;
      cnt_q      <= '0;
      hdr_q      <= '0;
      b1_q       <= '0;
      pkt_q      <= '0;
      pkt_vld_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      b1_q       <= b1_d;
      pkt_q      <= pkt_d;
      pkt_vld_q  <= pkt_vld_d;
      sync_err_q <= sync_err_d;
    end
  end

  ps2_cursor_accum #(
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX),
    .POS_W (POS_W)
  ) u_cursor (
    .iCLK_50 (iCLK_50),
    .iRST    (iRST),
    .iDX     (dx_eff),
    .iDY     (dy_eff),
    .iUPD    (pkt_vld_d),
    .iCLR    (iCLR_POS),
    .oCUR_X  (oCUR_X),
    .oCUR_Y  (oCUR_Y)
  );

  assign oLEFBUT    = pkt_q.l;
  assign oRIGBUT    = pkt_q.r;
  assign oMIDBUT    = pkt_q.m;
  assign oDX        = pkt_q.dx;
  assign oDY        = pkt_q.dy;
  assign oX_OVF     = pkt_q.xo;
  assign oY_OVF     = pkt_q.yo;
  assign oPKT_VALID = pkt_vld_q;
  assign oSYNC_ERR  = sync_err_q;

endmodule

// File: doc/ps2_mouse_packet_decoder.md
Name: ps2_mouse_packet_decoder

Overview:
Consumes the byte stream from the PS/2 receive stage of the mouse interface. Assembles standard 3-byte stream-mode packets and checks header sync. Exposes button state and signed 9-bit X/Y displacement, and maintains a clamped absolute cursor position for the VGA/HEX display stages downstream.

Parameters:
CLK_HZ, 50000000, frequency of iCLK_50 in Hz
TIMEOUT_US, 2000, maximum allowed gap between bytes of one packet, in microseconds
X_MAX, 639, largest valid cursor X value
Y_MAX, 479, largest valid cursor Y value
POS_W, 10, width of the cursor coordinates; must satisfy 2^POS_W > max(X_MAX, Y_MAX)

Ports:
iCLK_50  in  1  system clock
iRST  in  1  reset; one clock, synchronous, active-high
iBYTE  in  8  received byte from the PS/2 receiver
iBYTE_VALID  in  1  one-cycle strobe; iBYTE is valid in that cycle
iCLR_POS  in  1  recentre the cursor
oLEFBUT  out  1  left button, from the last valid packet
oRIGBUT  out  1  right button
oMIDBUT  out  1  middle button
oDX  out  9  signed X displacement of the last packet
oDY  out  9  signed Y displacement (positive = up)
oX_OVF  out  1  X overflow flag of the last packet
oY_OVF  out  1  Y overflow flag of the last packet
oPKT_VALID  out  1  one-cycle pulse when the outputs above update
oSYNC_ERR  out  1  one-cycle pulse on a dropped header or an inter-byte timeout
oCUR_X  out  POS_W  cursor X, range 0..X_MAX
oCUR_Y  out  POS_W  cursor Y, range 0..Y_MAX (0 = top of screen)

Behaviour:
- Reset state:
  - All flag, button and displacement outputs are 0.
  - oCUR_X = X_MAX/2 and oCUR_Y = Y_MAX/2, integer divide (319, 239 at defaults).
  - FSM in WAIT_B0; timeout counter is 0.
  - Reset mid-packet discards any partial packet.
- Header byte 0 layout:
  - bit0 = L, bit1 = R, bit2 = M, bit3 = always 1.
  - bit4 = X sign, bit5 = Y sign, bit6 = X overflow, bit7 = Y overflow.
  - Byte 1 is the low 8 bits of X; byte 2 is the low 8 bits of Y.
- FSM has three states: WAIT_B0, WAIT_B1, WAIT_B2. Bytes are only acted on when iBYTE_VALID = 1.
- WAIT_B0:
  - 0xFA (ACK) and 0xAA (BAT pass) are dropped silently. A genuine header equal to one of these values is also lost; this loss is accepted.
  - A byte with bit3 = 0 is dropped and oSYNC_ERR pulses.
  - Any other byte is latched as the header; go to WAIT_B1.
- WAIT_B1: latch byte 1; go to WAIT_B2.
- WAIT_B2: latch byte 2 and go to WAIT_B0. On the next clock edge:
  - All packet outputs are registered and oPKT_VALID = 1 for exactly one cycle.
  - Latency is 1 cycle from the byte-2 strobe to oPKT_VALID.
- Displacement:
  - oDX = {hdr[4], byte1} and oDY = {hdr[5], byte2}, two's complement, range -256..255.
- Timeout:
  - The counter clears on every accepted byte and counts only in WAIT_B1/WAIT_B2.
  - When it reaches TIMEOUT_CYC-1, where TIMEOUT_CYC = CLK_HZ/1000000*TIMEOUT_US, the FSM returns to WAIT_B0 and oSYNC_ERR pulses.
  - A byte strobe in the same cycle as the timeout wins: the byte is accepted and there is no error.
- Cursor update:
  - Happens on the same edge as oPKT_VALID; the new position is visible while oPKT_VALID = 1.
  - new_x = cur_x + dx_eff; new_y = cur_y - dy_eff.
  - dx_eff = 0 if the X overflow flag is set, otherwise oDX. dy_eff follows the same rule with the Y flag.
  - Sums are computed signed at POS_W+2 bits, then clamped: results below 0 become 0, results above X_MAX/Y_MAX become X_MAX/Y_MAX.
- iCLR_POS:
  - Sets the cursor to centre on the next edge.
  - If it coincides with a packet update, the clear wins for the cursor; the button and displacement outputs still update.
- oPKT_VALID and oSYNC_ERR are never asserted in the same cycle.

Decomposition:
- Package ps2_mouse_pkg holds:
  - header bit indices (L, R, M, SYNC, XS, YS, XO, YO);
  - PS2_ACK = 8'hFA and PS2_BAT = 8'hAA;
  - the FSM state enum;
  - a function that converts TIMEOUT_US to cycles.
- Sub-module ps2_cursor_accum holds the cursor registers, signed add, clamp and recentre logic.
  - Parameters: X_MAX, Y_MAX, POS_W.
  - Inputs: iDX, iDY, iUPD, iCLR.

Test Plan:
- Reset, then bytes 0x09, 0x05, 0x03 -> one cycle later oPKT_VALID = 1, oLEFBUT = 1, oDX = +5, oDY = +3, cursor (324, 236).
- Bytes 0x38, 0x00, 0xFE (X sign set, Y sign set, Y = -2) -> oDX = -256, oDY = -2, cursor (63, 241) from centre.
- Stream 0xFA, 0x02, then a valid packet -> 0xFA dropped silently; 0x02 raises oSYNC_ERR; the following packet decodes correctly.
- Header 0x08, then no byte for TIMEOUT_CYC cycles -> oSYNC_ERR pulse, FSM back to WAIT_B0. A byte arriving in the exact timeout cycle gives no error.
- Repeated dx = +255 packets -> oCUR_X saturates at 639. A packet with X overflow set (0x48, 0xFF, 0x00) leaves the cursor unchanged but oX_OVF = 1.
- iCLR_POS coincident with the byte-2-triggered update -> cursor = (319, 239) while buttons and displacement update. Reset asserted after byte 1 -> no oPKT_VALID; the next full packet decodes correctly.
